// File: rtl/pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_ctrl
//
// Arbitrates a two-slot (ping-pong) feature/kernel buffer between a DMA
// loader and an instruction decoder/compute unit. One slot is filled by the
// loader while the other is being computed on. Fill and compute both walk
// the slots in order 0, 1, 0, 1, ... Each slot moves through
// EMPTY -> LOADING -> READY -> COMPUTING -> EMPTY.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst_n          asynchronous, active-low reset
//   load_req       loader asks for a slot to fill
//   load_grant     one-cycle pulse, slot load_slot granted to the loader
//   load_slot      slot being filled, stable from grant until load_done
//   load_done      one-cycle pulse, loader finished the granted slot
//   load_last      sampled with load_done, slot holds the layer's last tile
//   inst_valid     a READY slot is offered to the decoder, held until accepted
//   decoder_ready  decoder accepts (handshake = inst_valid & decoder_ready)
//   which_slot     slot the decoder reads, held until compute_done
//   tlast          stored load_last of slot which_slot
//   compute_done   one-cycle pulse, compute on the active slot finished
//   slot_state     {slot1[1:0], slot0[1:0]}: 00 EMPTY 01 LOADING 10 READY
//                  11 COMPUTING
//   tile_cnt       tiles completed in the current layer
//   layer_done     one-cycle pulse when a last-tile slot completes
//   err            sticky protocol-error flag
//
// Configuration macros:
//   DATA_RANGE            bit range of tile_cnt (defaults to 7:0)
//   PPCTRL_ERR_DETECT_EN  when defined, builds the protocol checker that
//                         drives err; otherwise err is tied to 0
// ---------------------------------------------------------------------------

`ifndef DATA_RANGE
`define DATA_RANGE 7:0
`endif

module pingpong_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    output logic              load_grant,
    output logic              load_slot,
    input  logic              load_done,
    input  logic              load_last,
    output logic              inst_valid,
    input  logic              decoder_ready,
    output logic              which_slot,
    output logic              tlast,
    input  logic              compute_done,
    output logic [3:0]        slot_state,
    output logic [`DATA_RANGE] tile_cnt,
    output logic              layer_done,
    output logic              err
);

    localparam int CNT_W = $bits(tile_cnt);

    typedef enum logic [1:0] {
        SLOT_EMPTY     = 2'b00,
        SLOT_LOADING   = 2'b01,
        SLOT_READY     = 2'b10,
        SLOT_COMPUTING = 2'b11
    } slot_state_e;

    slot_state_e          slot_q [2];
    slot_state_e          slot_d [2];
    logic [1:0]           last_q;
    logic [1:0]           last_d;
    logic                 load_ptr_q;
    logic                 load_ptr_d;
    logic                 comp_ptr_q;
    logic                 comp_ptr_d;
    logic                 grant_q;
    logic                 grant_d;
    logic                 load_slot_q;
    logic                 load_slot_d;
    logic                 inst_valid_q;
    logic                 inst_valid_d;
    logic                 which_slot_q;
    logic                 which_slot_d;
    logic                 layer_done_q;
    logic                 layer_done_d;
    logic [CNT_W-1:0]     tile_cnt_q;
    logic [CNT_W-1:0]     tile_cnt_d;

    logic                 any_loading;
    logic                 any_computing;
    logic                 grant_fire;
    logic                 load_fin;
    logic                 issue_fire;
    logic                 handshake;
    logic                 comp_fin;

    // Only one slot can be LOADING (grants wait for it) and only one can be
    // COMPUTING (issue waits for it), so load_ptr always names the loading
    // slot and comp_ptr the computing one.
    assign any_loading   = (slot_q[0] == SLOT_LOADING)   || (slot_q[1] == SLOT_LOADING);
    assign any_computing = (slot_q[0] == SLOT_COMPUTING) || (slot_q[1] == SLOT_COMPUTING);

    assign grant_fire = load_req && (slot_q[load_ptr_q] == SLOT_EMPTY) && !any_loading;
    assign load_fin   = load_done && any_loading;
    assign issue_fire = !inst_valid_q && (slot_q[comp_ptr_q] == SLOT_READY) && !any_computing;
    assign handshake  = inst_valid_q && decoder_ready;
    assign comp_fin   = compute_done && any_computing;

    // Next-state logic. The events above each touch a different slot, so
    // load and compute completions in the same cycle both land.
    always_comb begin
        slot_d[0]    = slot_q[0];
        slot_d[1]    = slot_q[1];
        last_d       = last_q;
        load_ptr_d   = load_ptr_q;
        comp_ptr_d   = comp_ptr_q;
        grant_d      = 1'b0;
        load_slot_d  = load_slot_q;
        inst_valid_d = inst_valid_q;
        which_slot_d = which_slot_q;
        layer_done_d = 1'b0;
        tile_cnt_d   = tile_cnt_q;

        if (grant_fire) begin
            slot_d[load_ptr_q] = SLOT_LOADING;
            grant_d            = 1'b1;
            load_slot_d        = load_ptr_q;
        end

        if (load_fin) begin
            slot_d[load_ptr_q] = SLOT_READY;
            last_d[load_ptr_q] = load_last;
            load_ptr_d         = ~load_ptr_q;
        end

        if (issue_fire) begin
            inst_valid_d = 1'b1;
            which_slot_d = comp_ptr_q;
        end

        if (handshake) begin
            slot_d[which_slot_q] = SLOT_COMPUTING;
            inst_valid_d         = 1'b0;
        end

        // A completed last tile closes the layer: the count restarts at 0
        // and the slot's last flag is cleared so tlast cannot go stale.
        if (comp_fin) begin
            slot_d[comp_ptr_q] = SLOT_EMPTY;
            last_d[comp_ptr_q] = 1'b0;
            comp_ptr_d         = ~comp_ptr_q;
            if (last_q[comp_ptr_q]) begin
                tile_cnt_d   = '0;
                layer_done_d = 1'b1;
            end else begin
                tile_cnt_d = tile_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0]    <= SLOT_EMPTY;
            slot_q[1]    <= SLOT_EMPTY;
            last_q       <= 2'b00;
            load_ptr_q   <= 1'b0;
            comp_ptr_q   <= 1'b0;
            grant_q      <= 1'b0;
            load_slot_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            which_slot_q <= 1'b0;
            layer_done_q <= 1'b0;
            tile_cnt_q   <= '0;
        end else begin
            slot_q[0]    <= slot_d[0];
            slot_q[1]    <= slot_d[1];
            last_q       <= last_d;
            load_ptr_q   <= load_ptr_d;
            comp_ptr_q   <= comp_ptr_d;
            grant_q      <= grant_d;
            load_slot_q  <= load_slot_d;
            inst_valid_q <= inst_valid_d;
            which_slot_q <= which_slot_d;
            layer_done_q <= layer_done_d;
            tile_cnt_q   <= tile_cnt_d;
        end
    end

    assign load_grant = grant_q;
    assign load_slot  = load_slot_q;
    assign inst_valid = inst_valid_q;
    assign which_slot = which_slot_q;
    assign tlast      = last_q[which_slot_q];
    assign slot_state = {slot_q[1], slot_q[0]};
    assign tile_cnt   = tile_cnt_q;
    assign layer_done = layer_done_q;

`ifdef PPCTRL_ERR_DETECT_EN
    logic err_q;
    logic err_event;

    // Flags stray completions and a loader that keeps requesting after its
    // grant pulse while the granted load is still outstanding.
    assign err_event = (load_done && !any_loading)
                    || (compute_done && !any_computing)
                    || (load_req && any_loading && !grant_q && !load_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 clk  input  1  single clock; all state on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 load_req  input  1  DMA loader requests a feature/kernel slot to fill.
REQ-004 load_grant  output  1  one-cycle pulse; the slot named by load_slot is granted to the loader.
REQ-005 load_slot  output  1  slot index being filled; stable from grant until load_done.
REQ-006 load_done  input  1  one-cycle pulse; loader finished the granted slot.
REQ-007 load_last  input  1  sampled with load_done; slot holds the final tile of the layer.
REQ-008 inst_valid  output  1  slot ready for the decoder; held until accepted.
REQ-009 decoder_ready  input  1  decoder accepts; handshake is inst_valid & decoder_ready on a rising edge.
REQ-010 which_slot  output  1  ping-pong buffer select for the decoder's BRAM reads.
REQ-011 tlast  output  1  stored load_last of slot which_slot; valid while inst_valid.
REQ-012 compute_done  input  1  one-cycle pulse; decoder/CU finished the slot, write-back drained.
REQ-013 slot_state  output  4  {slot1[1:0], slot0[1:0]}: 00 EMPTY, 01 LOADING, 10 READY, 11 COMPUTING.
REQ-014 tile_cnt  output  `DATA_RANGE  tiles completed in the current layer.
REQ-015 layer_done  output  1  one-cycle pulse when a last-tile slot completes.
REQ-016 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-017 Each slot SHALL have a 2-bit state; transitions are EMPTY->LOADING->READY->COMPUTING->EMPTY only.
REQ-018 load_ptr and comp_ptr SHALL each start at 0 and toggle, so fill and compute alternate slot 0, 1, 0, ...
REQ-019 Grant: when load_req=1, slot[load_ptr]=EMPTY and no slot is LOADING, the block SHALL pulse load_grant next cycle with load_slot=load_ptr, and the slot SHALL become LOADING.
REQ-020 load_req while slot[load_ptr] is not EMPTY SHALL be held off with no grant until that slot becomes EMPTY; the requester keeps load_req high.
REQ-021 A load_done while a slot is LOADING SHALL set that slot READY, store load_last, and toggle load_ptr.
REQ-022 Issue: when slot[comp_ptr]=READY and no slot is COMPUTING, inst_valid SHALL rise next cycle with which_slot=comp_ptr; inst_valid, which_slot and tlast SHALL stay stable until the handshake.
REQ-023 On the handshake the slot SHALL become COMPUTING and inst_valid SHALL drop next cycle; which_slot SHALL hold until compute_done.
REQ-024 compute_done while a slot is COMPUTING SHALL set it EMPTY, toggle comp_ptr and increment tile_cnt by 1 (wraps at 2^width).
REQ-025 If the completed slot had load_last=1, layer_done SHALL pulse in the same cycle that slot_state shows EMPTY, and tile_cnt SHALL clear to 0 instead of incrementing.
REQ-026 Simultaneous load_done and compute_done on different slots SHALL both take effect in the same cycle.
REQ-027 A compute_done that frees slot[load_ptr] while load_req is pending SHALL allow the grant on the following cycle; there is no combinational path from inputs to outputs.
REQ-028 load_done with no slot LOADING, or compute_done with no slot COMPUTING, SHALL change no state.

Reset
REQ-029 While rst_n=0: both slots EMPTY, load_ptr=comp_ptr=0, load_grant=0, load_slot=0, inst_valid=0, which_slot=0, tlast=0, tile_cnt=0, layer_done=0, err=0.
REQ-030 Reset asserted mid-load or mid-compute SHALL abort all transactions; after release the loader and decoder SHALL restart from slot 0.

Configuration
REQ-031 Macro PPCTRL_ERR_DETECT_EN: when defined, err SHALL be set one cycle after any event in REQ-028, or after load_req is held 1 in a cycle where load_grant was already pulsed and load_done has not yet arrived; err clears only on reset.
REQ-032 Without PPCTRL_ERR_DETECT_EN, err SHALL be constant 0 and the detection logic SHALL not be built.

Verification
REQ-033 Single tile: load_req=1 -> grant slot 0; load_done with load_last=1 -> inst_valid, which_slot=0, tlast=1; decoder_ready=1 -> slot0=COMPUTING; compute_done -> layer_done pulse, tile_cnt=0.
REQ-034 Overlap: load 4 tiles (last on 4th) with decoder_ready always 1 -> slots alternate 0,1,0,1; slot 1 loads while slot 0 computes; tile_cnt reads 1,2,3, then 0 with layer_done.
REQ-035 Backpressure: both slots READY, decoder_ready=0 for 10 cycles -> inst_valid, which_slot=0 and tlast stay stable; load_req gets no grant until the first compute_done.
REQ-036 Same-cycle events: load_done on slot 1 in the same cycle as compute_done on slot 0 -> slot_state goes 4'b0111 to 4'b1000 in one cycle.
REQ-037 Reset abort: rst_n=0 while slot 0 is COMPUTING and slot 1 is LOADING -> all outputs are at reset values immediately (asynchronously); the next grant is slot 0.
REQ-038 With PPCTRL_ERR_DETECT_EN: compute_done at idle -> err=1 next cycle, and err stays high; without the macro err stays 0.
